// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader: FSM state encodings and
// default frame geometry used by the loader and its timeout counter.
package serial_word_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_PARITY_EN = 1;
    localparam int DEFAULT_TIMEOUT   = 15;

endpackage

// File: rtl/serial_word_loader_if.sv
// Serial input stream plus the parallel-load outputs of the word loader.
// master drives the stream and observes results; slave is the loader itself.
interface serial_word_loader_if import serial_word_loader_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             sin_valid;
    logic             sin_data;
    logic             sin_start;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             frame_err;

    modport master (
        output sin_valid, sin_data, sin_start,
        input  load, d, busy, frame_err
    );

    modport slave (
        input  sin_valid, sin_data, sin_start,
        output load, d, busy, frame_err
    );

endinterface

// File: rtl/serial_word_loader_timeout.sv
// Saturating idle counter shared by serial front-ends. expired flags the idle
// cycle whose closing edge brings the count up to TIMEOUT.
module frame_timeout_counter import serial_word_loader_pkg::*; #(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // Announcing one cycle early lets the FSM leave the frame on the same edge
    // that the count reaches TIMEOUT.
    assign expired = enable && !clear && (count >= (LIMIT - CW'(1)));

endmodule

// File: rtl/serial_word_loader.sv
// Collects an MSB-first serial frame, checks optional even parity and hands a
// good word to a parallel-load register with a single-cycle load pulse.
module serial_word_loader import serial_word_loader_pkg::*; #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PARITY_EN = DEFAULT_PARITY_EN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input logic                  clk,
    input logic                  reset,
    serial_word_loader_if.slave  bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_reg;
    logic             err_next;
    logic             in_frame;
    logic             expired;

    function automatic state_t after_data(input logic [CNT_W-1:0] n);
        if (n == CNT_FULL) begin
            return (PARITY_EN != 0) ? ST_PARITY : ST_LOAD;
        end
        return ST_SHIFT;
    endfunction

    assign in_frame = (state == ST_SHIFT) || (state == ST_PARITY);

    frame_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (in_frame && !bus.sin_valid),
        .clear   (bus.sin_valid || !in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            err_reg   <= 1'b0;
            d_reg     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            cnt       <= cnt_next;
            err_reg   <= err_next;
            if (state_next == ST_LOAD) begin
                d_reg <= shift_next;
            end
        end
    end

    // A start bit always opens a fresh frame, even when it cuts one short.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = cnt;
        err_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.sin_valid && bus.sin_start) begin
                    shift_next = WIDTH'(bus.sin_data);
                    cnt_next   = CNT_W'(1);
                    state_next = after_data(CNT_W'(1));
                end
            end
            ST_SHIFT, ST_PARITY: begin
                if (bus.sin_valid) begin
                    if (bus.sin_start) begin
                        err_next   = 1'b1;
                        shift_next = WIDTH'(bus.sin_data);
                        cnt_next   = CNT_W'(1);
                        state_next = after_data(CNT_W'(1));
                    end else if (state == ST_SHIFT) begin
                        shift_next = WIDTH'({shift_reg, bus.sin_data});
                        cnt_next   = cnt + CNT_W'(1);
                        state_next = after_data(cnt + CNT_W'(1));
                    end else if (bus.sin_data == ^shift_reg) begin
                        state_next = ST_LOAD;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next == ST_IDLE) begin
            cnt_next = '0;
        end
    end

    assign bus.load      = (state == ST_LOAD);
    assign bus.d         = d_reg;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.frame_err = err_reg;

endmodule

// File: tb/tb_serial_word_loader.sv
// Scenario bench for serial_word_loader: expected words are queued as frames
// are sent and popped when the loader pulses load.
module tb_serial_word_loader;
    import serial_word_loader_pkg::*;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    serial_word_loader_if #(.WIDTH(WIDTH)) bus ();

    serial_word_loader #(
        .WIDTH     (WIDTH),
        .PARITY_EN (1),
        .TIMEOUT   (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int load_seen = 0;
    int err_seen = 0;

    // Stand-in for the downstream register4bit.
    always @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else if (bus.load) q <= bus.d;
    end

    always @(posedge clk) begin
        if (reset) begin
            if (bus.load) load_seen++;
            if (bus.frame_err) err_seen++;
        end
    end

    task automatic send_bit(input logic s, input logic b);
        @(negedge clk);
        bus.sin_valid = 1'b1;
        bus.sin_start = s;
        bus.sin_data  = b;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
        bus.sin_data  = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic p);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(i == WIDTH - 1, w[i]);
        end
        send_bit(1'b0, p);
    endtask

    task automatic wait_load(output int lat);
        lat = 0;
        while (bus.load !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: got %b expected 0", bus.load); end
        checks++; if (bus.d !== 4'b0000) begin errors++; $display("[TB] FAIL reset_d: got %b expected 0000", bus.d); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.d !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset: got d=%b busy=%b expected d=0000 busy=0", bus.d, bus.busy); end
    endtask

    task automatic test_ignored_bits();
        int e0 = err_seen;
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        go_idle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        checks++; if (err_seen !== e0) begin errors++; $display("[TB] FAIL idle_ignore_err: got %0d errors expected %0d", err_seen, e0); end
    endtask

    task automatic test_good_frame();
        int e0 = err_seen;
        int l0 = load_seen;
        int lat;
        logic [WIDTH-1:0] exp;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL good_busy: got %b expected 1", bus.busy); end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        exp_q.push_back(4'b1011);
        go_idle();
        wait_load(lat);
        checks++; if (lat != 0 || bus.load !== 1'b1) begin errors++; $display("[TB] FAIL good_latency: got %0d cycles expected 0", lat); end
        exp = exp_q.pop_front();
        checks++; if (bus.d !== exp) begin errors++; $display("[TB] FAIL good_d: got %b expected %b", bus.d, exp); end
        @(negedge clk);
        checks++; if (bus.load !== 1'b0) begin errors++; $display("[TB] FAIL good_load_width: got %b expected 0", bus.load); end
        checks++; if (q !== exp) begin errors++; $display("[TB] FAIL good_q: got %b expected %b", q, exp); end
        checks++; if (err_seen !== e0 || load_seen !== l0 + 1) begin errors++; $display("[TB] FAIL good_counts: got err=%0d load=%0d expected err=%0d load=%0d", err_seen, load_seen, e0, l0 + 1); end
    endtask

    task automatic test_parity_error();
        int l0 = load_seen;
        send_frame(4'b1011, 1'b0);
        go_idle();
        checks++; if (bus.frame_err !== 1'b1 || bus.load !== 1'b0) begin errors++; $display("[TB] FAIL parity_err: got err=%b load=%b expected err=1 load=0", bus.frame_err, bus.load); end
        @(negedge clk);
        checks++; if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL parity_after: got err=%b busy=%b expected 0 0", bus.frame_err, bus.busy); end
        checks++; if (bus.d !== 4'b1011) begin errors++; $display("[TB] FAIL parity_d_hold: got %b expected 1011", bus.d); end
        repeat (2) @(negedge clk);
        checks++; if (load_seen !== l0) begin errors++; $display("[TB] FAIL parity_no_load: got %0d loads expected %0d", load_seen, l0); end
    endtask

    task automatic test_early_start();
        int e0 = err_seen;
        int lat;
        logic [WIDTH-1:0] exp;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++; if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL early_err: got err=%b busy=%b expected 1 1", bus.frame_err, bus.busy); end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        exp_q.push_back(4'b0110);
        go_idle();
        wait_load(lat);
        checks++; if (lat != 0 || bus.load !== 1'b1) begin errors++; $display("[TB] FAIL early_latency: got %0d cycles expected 0", lat); end
        exp = exp_q.pop_front();
        checks++; if (bus.d !== exp) begin errors++; $display("[TB] FAIL early_d: got %b expected %b", bus.d, exp); end
        @(negedge clk);
        checks++; if (err_seen !== e0 + 1) begin errors++; $display("[TB] FAIL early_err_count: got %0d expected %0d", err_seen, e0 + 1); end
    endtask

    task automatic test_timeout_boundary();
        int e0 = err_seen;
        int lat;
        logic [WIDTH-1:0] exp;
        send_bit(1'b1, 1'b1);
        go_idle();
        repeat (13) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL gap14_alive: got busy=%b err=%b expected 1 0", bus.busy, bus.frame_err); end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        exp_q.push_back(4'b1010);
        go_idle();
        wait_load(lat);
        checks++; if (lat != 0 || bus.load !== 1'b1) begin errors++; $display("[TB] FAIL gap14_latency: got %0d cycles expected 0", lat); end
        exp = exp_q.pop_front();
        checks++; if (bus.d !== exp) begin errors++; $display("[TB] FAIL gap14_d: got %b expected %b", bus.d, exp); end
        @(negedge clk);
        checks++; if (err_seen !== e0) begin errors++; $display("[TB] FAIL gap14_no_err: got %0d expected %0d", err_seen, e0); end
    endtask

    task automatic test_stall();
        int l0 = load_seen;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        go_idle();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (bus.frame_err !== (i == 15)) begin errors++; $display("[TB] FAIL stall_err_%0d: got %b expected %b", i, bus.frame_err, (i == 15)); end
            checks++;
            if (bus.busy !== (i < 15)) begin errors++; $display("[TB] FAIL stall_busy_%0d: got %b expected %b", i, bus.busy, (i < 15)); end
        end
        checks++; if (load_seen !== l0) begin errors++; $display("[TB] FAIL stall_no_load: got %0d loads expected %0d", load_seen, l0); end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        logic [WIDTH-1:0] exp;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.d !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_clear: got d=%b busy=%b expected 0000 0", bus.d, bus.busy); end
        checks++; if (bus.load !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulses: got load=%b err=%b expected 0 0", bus.load, bus.frame_err); end
        @(negedge clk);
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
        reset = 1'b1;
        send_frame(4'b0111, 1'b1);
        exp_q.push_back(4'b0111);
        go_idle();
        wait_load(lat);
        checks++; if (lat != 0 || bus.load !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_latency: got %0d cycles expected 0", lat); end
        exp = exp_q.pop_front();
        checks++; if (bus.d !== exp) begin errors++; $display("[TB] FAIL after_reset_d: got %b expected %b", bus.d, exp); end
        @(negedge clk);
        checks++; if (q !== exp) begin errors++; $display("[TB] FAIL after_reset_q: got %b expected %b", q, exp); end
    endtask

    initial begin
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
        bus.sin_data  = 1'b0;
        test_reset();
        test_ignored_bits();
        test_good_frame();
        test_parity_error();
        test_early_start();
        test_timeout_boundary();
        test_stall();
        test_reset_mid_frame();
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
